// File: rtl/exe_mem_stage.sv
`timescale 1ns/1ps
// EX->MEM pipeline register with architectural flag register and branch resolution.
// Latency: 1 cycle from EX inputs to mm_*/br_* outputs; flags visible on f_* the cycle after capture.
// Backpressure: stall holds every register (br_taken drops); flush inserts a bubble and wins over stall.
module exe_mem_stage (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_r,
  input  logic        ex_zf,
  input  logic        ex_sf,
  input  logic        ex_cf,
  input  logic [31:0] ex_b,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic        ex_setf,
  input  logic        ex_br,
  input  logic [2:0]  ex_cond,
  input  logic [31:0] ex_target,
  output logic        mm_valid,
  output logic [31:0] mm_r,
  output logic [31:0] mm_b,
  output logic [4:0]  mm_rd,
  output logic        mm_wreg,
  output logic        mm_m2reg,
  output logic        mm_wmem,
  output logic        f_zf,
  output logic        f_sf,
  output logic        f_cf,
  output logic        br_taken,
  output logic [31:0] br_target
);

  // Condition codes
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_CS = 3'b101;
  localparam logic [2:0] COND_CC = 3'b110;
  localparam logic [2:0] COND_LE = 3'b111;

  // Registered state and next-state
  logic        mm_valid_q,  mm_valid_d;
  logic [31:0] mm_r_q,      mm_r_d;
  logic [31:0] mm_b_q,      mm_b_d;
  logic [4:0]  mm_rd_q,     mm_rd_d;
  logic        mm_wreg_q,   mm_wreg_d;
  logic        mm_m2reg_q,  mm_m2reg_d;
  logic        mm_wmem_q,   mm_wmem_d;
  logic        f_zf_q,      f_zf_d;
  logic        f_sf_q,      f_sf_d;
  logic        f_cf_q,      f_cf_d;
  logic        br_taken_q,  br_taken_d;
  logic [31:0] br_target_q, br_target_d;

  logic acc;
  logic bubble;
  logic cond_true;
  logic take;

  // Accept/bubble qualification; flush beats stall, an empty EX slot only bubbles when not stalled
  always_comb begin
    acc    = ex_valid & ~stall & ~flush;
    bubble = flush | (~ex_valid & ~stall);
  end

  // Branch condition against the flags currently held (before any same-cycle update).
  // Signed conditions deliberately use the sign flag alone, with no overflow term.
  always_comb begin
    cond_true = 1'b0;
    case (ex_cond)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = f_zf_q;
      COND_NE: cond_true = ~f_zf_q;
      COND_LT: cond_true = f_sf_q;
      COND_GE: cond_true = ~f_sf_q;
      COND_CS: cond_true = f_cf_q;
      COND_CC: cond_true = ~f_cf_q;
      COND_LE: cond_true = f_zf_q | f_sf_q;
      default: cond_true = 1'b0;
    endcase
    take = acc & ex_br & cond_true;
  end

  // Next-state: capture, bubble or hold for the pipeline slot, flags and branch outputs
  always_comb begin
    mm_valid_d  = mm_valid_q;
    mm_r_d      = mm_r_q;
    mm_b_d      = mm_b_q;
    mm_rd_d     = mm_rd_q;
    mm_wreg_d   = mm_wreg_q;
    mm_m2reg_d  = mm_m2reg_q;
    mm_wmem_d   = mm_wmem_q;
    f_zf_d      = f_zf_q;
    f_sf_d      = f_sf_q;
    f_cf_d      = f_cf_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;

    if (bubble) begin
      // Data fields are don't-care in a bubble; holding them saves enables toggling
      mm_valid_d = 1'b0;
      mm_wreg_d  = 1'b0;
      mm_m2reg_d = 1'b0;
      mm_wmem_d  = 1'b0;
    end else if (acc) begin
      mm_valid_d = 1'b1;
      mm_r_d     = ex_r;
      mm_b_d     = ex_b;
      mm_rd_d    = ex_rd;
      mm_wreg_d  = ex_wreg;
      mm_m2reg_d = ex_m2reg;
      mm_wmem_d  = ex_wmem;
    end

    if (acc && ex_setf) begin
      f_zf_d = ex_zf;
      f_sf_d = ex_sf;
      f_cf_d = ex_cf;
    end

    br_taken_d = take;
    if (take) begin
      br_target_d = ex_target;
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mm_valid_q  <= 1'b0;
      mm_r_q      <= 32'd0;
      mm_b_q      <= 32'd0;
      mm_rd_q     <= 5'd0;
      mm_wreg_q   <= 1'b0;
      mm_m2reg_q  <= 1'b0;
      mm_wmem_q   <= 1'b0;
      f_zf_q      <= 1'b0;
      f_sf_q      <= 1'b0;
      f_cf_q      <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= 32'd0;
    end else begin
      mm_valid_q  <= mm_valid_d;
      mm_r_q      <= mm_r_d;
      mm_b_q      <= mm_b_d;
      mm_rd_q     <= mm_rd_d;
      mm_wreg_q   <= mm_wreg_d;
      mm_m2reg_q  <= mm_m2reg_d;
      mm_wmem_q   <= mm_wmem_d;
      f_zf_q      <= f_zf_d;
      f_sf_q      <= f_sf_d;
      f_cf_q      <= f_cf_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  // Output drive
  always_comb begin
    mm_valid  = mm_valid_q;
    mm_r      = mm_r_q;
    mm_b      = mm_b_q;
    mm_rd     = mm_rd_q;
    mm_wreg   = mm_wreg_q;
    mm_m2reg  = mm_m2reg_q;
    mm_wmem   = mm_wmem_q;
    f_zf      = f_zf_q;
    f_sf      = f_sf_q;
    f_cf      = f_cf_q;
    br_taken  = br_taken_q;
    br_target = br_target_q;
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
`timescale 1ns/1ps
// Bench for exe_mem_stage: vector table driven through a scoreboard queue,
// plus hand sequences for multi-cycle stall and asynchronous reset.
module tb_exe_mem_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stall, flush, ex_valid;
  logic [31:0] ex_r, ex_b, ex_target;
  logic        ex_zf, ex_sf, ex_cf;
  logic [4:0]  ex_rd;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_setf, ex_br;
  logic [2:0]  ex_cond;
  logic        mm_valid, mm_wreg, mm_m2reg, mm_wmem;
  logic [31:0] mm_r, mm_b, br_target;
  logic [4:0]  mm_rd;
  logic        f_zf, f_sf, f_cf, br_taken;

  int n_checks = 0;
  int n_fail   = 0;

  exe_mem_stage dut (
    .clk(clk), .clrn(clrn), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_r(ex_r), .ex_zf(ex_zf), .ex_sf(ex_sf), .ex_cf(ex_cf), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_setf(ex_setf), .ex_br(ex_br), .ex_cond(ex_cond), .ex_target(ex_target),
    .mm_valid(mm_valid), .mm_r(mm_r), .mm_b(mm_b), .mm_rd(mm_rd),
    .mm_wreg(mm_wreg), .mm_m2reg(mm_m2reg), .mm_wmem(mm_wmem),
    .f_zf(f_zf), .f_sf(f_sf), .f_cf(f_cf), .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  // Columns: inputs (v st fl r b rd ctl{wreg,m2reg,wmem} setf flg{z,s,c} br cond tgt)
  //          expected (ev er eb erd ectl eflg ebt etgt)
  typedef struct {
    logic        v, st, fl;
    logic [31:0] r, b;
    logic [4:0]  rd;
    logic [2:0]  ctl;
    logic        setf;
    logic [2:0]  flg;
    logic        br;
    logic [2:0]  cond;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] er, eb;
    logic [4:0]  erd;
    logic [2:0]  ectl;
    logic [2:0]  eflg;
    logic        ebt;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[19];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic fl, input logic [31:0] r,
                       input logic [31:0] b, input logic [4:0] rd, input logic [2:0] ctl,
                       input logic setf, input logic [2:0] flg, input logic br,
                       input logic [2:0] cond, input logic [31:0] tgt);
    ex_valid = v;  stall = st;  flush = fl;
    ex_r = r;  ex_b = b;  ex_rd = rd;
    {ex_wreg, ex_m2reg, ex_wmem} = ctl;
    ex_setf = setf;
    {ex_zf, ex_sf, ex_cf} = flg;
    ex_br = br;  ex_cond = cond;  ex_target = tgt;
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [31:0] er,
                           input logic [31:0] eb, input logic [4:0] erd, input logic [2:0] ectl,
                           input logic [2:0] eflg, input logic ebt, input logic [31:0] etgt);
    chk({tag, ".mm_valid"},  {31'd0, mm_valid}, {31'd0, ev});
    chk({tag, ".mm_r"},      mm_r, er);
    chk({tag, ".mm_b"},      mm_b, eb);
    chk({tag, ".mm_rd"},     {27'd0, mm_rd}, {27'd0, erd});
    chk({tag, ".mm_ctl"},    {29'd0, mm_wreg, mm_m2reg, mm_wmem}, {29'd0, ectl});
    chk({tag, ".flags"},     {29'd0, f_zf, f_sf, f_cf}, {29'd0, eflg});
    chk({tag, ".br_taken"},  {31'd0, br_taken}, {31'd0, ebt});
    chk({tag, ".br_target"}, br_target, etgt);
  endtask

  initial begin
    vec_t e;
    logic [2:0] hold_flg;

    //            v  st fl r          b       rd  ctl   setf flg   br cond  tgt         ev er         eb      erd ectl  eflg  ebt etgt
    vecs[0]  = '{1, 0, 0, 32'h1234, 32'hA0, 5,  3'b100, 1, 3'b001, 0, 3'd0, 32'h0,     1, 32'h1234, 32'hA0, 5,  3'b100, 3'b001, 0, 32'h0};
    vecs[1]  = '{1, 0, 0, 32'h0,    32'hA1, 3,  3'b100, 1, 3'b100, 0, 3'd0, 32'h0,     1, 32'h0,    32'hA1, 3,  3'b100, 3'b100, 0, 32'h0};
    vecs[2]  = '{1, 0, 0, 32'h40,   32'hA2, 0,  3'b000, 0, 3'b000, 1, 3'd1, 32'h40,    1, 32'h40,   32'hA2, 0,  3'b000, 3'b100, 1, 32'h40};
    vecs[3]  = '{1, 0, 0, 32'h80,   32'hA3, 0,  3'b000, 0, 3'b000, 1, 3'd2, 32'h80,    1, 32'h80,   32'hA3, 0,  3'b000, 3'b100, 0, 32'h40};
    vecs[4]  = '{0, 0, 0, 32'h999,  32'hA4, 7,  3'b101, 1, 3'b011, 1, 3'd0, 32'h99,    0, 32'h80,   32'hA3, 0,  3'b000, 3'b100, 0, 32'h40};
    vecs[5]  = '{1, 0, 0, 32'h5,    32'hA5, 1,  3'b100, 1, 3'b000, 0, 3'd0, 32'h0,     1, 32'h5,    32'hA5, 1,  3'b100, 3'b000, 0, 32'h40};
    vecs[6]  = '{1, 0, 0, 32'h100,  32'hA6, 0,  3'b000, 1, 3'b100, 1, 3'd1, 32'h100,   1, 32'h100,  32'hA6, 0,  3'b000, 3'b100, 0, 32'h40};
    vecs[7]  = '{1, 0, 0, 32'h200,  32'hA7, 0,  3'b000, 0, 3'b000, 1, 3'd7, 32'h200,   1, 32'h200,  32'hA7, 0,  3'b000, 3'b100, 1, 32'h200};
    vecs[8]  = '{1, 0, 0, 32'h3000, 32'hA8, 9,  3'b110, 1, 3'b010, 1, 3'd3, 32'h300,   1, 32'h3000, 32'hA8, 9,  3'b110, 3'b010, 0, 32'h200};
    vecs[9]  = '{1, 0, 0, 32'h400,  32'hA9, 0,  3'b000, 0, 3'b000, 1, 3'd3, 32'h400,   1, 32'h400,  32'hA9, 0,  3'b000, 3'b010, 1, 32'h400};
    vecs[10] = '{1, 1, 0, 32'hDEAD, 32'hAA, 4,  3'b111, 1, 3'b111, 1, 3'd0, 32'hAAA,   1, 32'h400,  32'hA9, 0,  3'b000, 3'b010, 0, 32'h400};
    vecs[11] = '{1, 1, 1, 32'h77,   32'hAB, 6,  3'b001, 1, 3'b111, 1, 3'd0, 32'h500,   0, 32'h400,  32'hA9, 0,  3'b000, 3'b010, 0, 32'h400};
    vecs[12] = '{1, 0, 1, 32'h88,   32'hAC, 6,  3'b100, 0, 3'b000, 1, 3'd0, 32'h550,   0, 32'h400,  32'hA9, 0,  3'b000, 3'b010, 0, 32'h400};
    vecs[13] = '{1, 0, 0, 32'h600,  32'hAD, 2,  3'b001, 0, 3'b000, 1, 3'd0, 32'h600,   1, 32'h600,  32'hAD, 2,  3'b001, 3'b010, 1, 32'h600};
    vecs[14] = '{1, 0, 0, 32'h700,  32'hAE, 0,  3'b000, 1, 3'b001, 1, 3'd6, 32'h700,   1, 32'h700,  32'hAE, 0,  3'b000, 3'b001, 1, 32'h700};
    vecs[15] = '{1, 0, 0, 32'h800,  32'hAF, 0,  3'b000, 0, 3'b000, 1, 3'd5, 32'h800,   1, 32'h800,  32'hAF, 0,  3'b000, 3'b001, 1, 32'h800};
    vecs[16] = '{1, 0, 0, 32'h900,  32'hB0, 0,  3'b000, 0, 3'b000, 1, 3'd4, 32'h900,   1, 32'h900,  32'hB0, 0,  3'b000, 3'b001, 1, 32'h900};
    vecs[17] = '{0, 0, 0, 32'h0,    32'hB1, 0,  3'b000, 0, 3'b000, 0, 3'd0, 32'h0,     0, 32'h900,  32'hB0, 0,  3'b000, 3'b001, 0, 32'h900};
    vecs[18] = '{1, 0, 0, 32'hA00,  32'hB2, 0,  3'b000, 0, 3'b000, 1, 3'd7, 32'hA00,   1, 32'hA00,  32'hB2, 0,  3'b000, 3'b001, 0, 32'h900};

    // Reset state, asserted before any clock edge
    clrn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 3'b000, 0, 3'b000, 0, 3'd0, 0);
    #2;
    chk_state("reset", 0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
    @(negedge clk);
    clrn = 1'b1;

    // Table: drive on the falling edge, compare just after the next rising edge
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].st, vecs[i].fl, vecs[i].r, vecs[i].b, vecs[i].rd, vecs[i].ctl,
            vecs[i].setf, vecs[i].flg, vecs[i].br, vecs[i].cond, vecs[i].tgt);
      sb_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk_state($sformatf("vec%0d", i), e.ev, e.er, e.eb, e.erd, e.ectl, e.eflg, e.ebt, e.etgt);
      end
      @(negedge clk);
    end

    // Taken branch that also sets flags; then 3 stalled cycles with changing inputs
    drive(1, 0, 0, 32'hC00, 32'hC1, 12, 3'b100, 1, 3'b110, 1, 3'd0, 32'hC00);
    @(posedge clk); #1;
    chk_state("pre_stall", 1, 32'hC00, 32'hC1, 12, 3'b100, 3'b110, 1, 32'hC00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hold_flg = 3'($urandom_range(0, 7));
      drive(1, 1, 0, $urandom, $urandom, 5'($urandom_range(0, 31)), 3'b111, 1, hold_flg,
            1, 3'd0, $urandom);
      @(posedge clk); #1;
      chk_state($sformatf("stall%0d", k), 1, 32'hC00, 32'hC1, 12, 3'b100, 3'b110, 0, 32'hC00);
    end
    @(negedge clk);
    drive(1, 0, 0, 32'hD00, 32'hD1, 13, 3'b010, 0, 3'b000, 0, 3'd0, 32'h0);
    @(posedge clk); #1;
    chk_state("stall_release", 1, 32'hD00, 32'hD1, 13, 3'b010, 3'b110, 0, 32'hC00);

    // Asynchronous reset mid-cycle with loaded registers
    @(negedge clk);
    #2;
    clrn = 1'b0;
    #1;
    chk_state("async_reset", 0, 0, 0, 0, 3'b000, 3'b000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage.md
# exe_mem_stage

Execute-to-memory pipeline register for the 32-bit CPU, sitting directly downstream of the ALU. Each cycle it captures the ALU result and the zero/sign/carry flags of the instruction in EX, together with its memory/writeback controls. It holds the architectural flag register and resolves conditional branches against it. It supports pipeline stall (hold) and flush (bubble insertion).

## Interface
Parameters: none; all widths fixed (32-bit datapath, 5-bit register index).

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset; the only reset
- stall  in  1  hold all state this cycle
- flush  in  1  replace the captured instruction with a bubble
- ex_valid  in  1  EX slot holds a real instruction
- ex_r  in  32  ALU result
- ex_zf, ex_sf, ex_cf  in  1 each  ALU zero, sign and carry flags
- ex_b  in  32  store data operand
- ex_rd  in  5  destination register
- ex_wreg  in  1  instruction writes the register file
- ex_m2reg  in  1  writeback value comes from memory
- ex_wmem  in  1  instruction writes memory
- ex_setf  in  1  instruction updates the flag register
- ex_br  in  1  instruction is a conditional branch
- ex_cond  in  3  branch condition code
- ex_target  in  32  branch target address
- mm_valid  out  1  MEM slot valid
- mm_r  out  32  registered ALU result (memory address or writeback data)
- mm_b  out  32  registered store data
- mm_rd  out  5  registered destination register
- mm_wreg, mm_m2reg, mm_wmem  out  1 each  registered controls
- f_zf, f_sf, f_cf  out  1 each  architectural flag register
- br_taken  out  1  one-cycle branch-taken pulse
- br_target  out  32  target address accompanying br_taken

## Operation
- **Accept condition:** `acc = ex_valid & ~stall & ~flush`.
- **Priority:** flush > stall > normal capture.
- **Normal capture (acc = 1):**
  - mm_valid <= 1.
  - mm_r, mm_b, mm_rd, mm_m2reg <= their ex_ inputs.
  - mm_wreg <= ex_wreg; mm_wmem <= ex_wmem.
- **Bubble** (flush = 1, or ~ex_valid with ~stall):
  - mm_valid, mm_wreg, mm_wmem, mm_m2reg <= 0.
  - mm_r, mm_b, mm_rd are don't-care but held.
- **Stall without flush:** every register holds, including flags. br_taken <= 0.
- **Flag register:** on acc & ex_setf, {f_zf, f_sf, f_cf} <= {ex_zf, ex_sf, ex_cf}. Otherwise it holds.
- **Branch condition codes** (evaluated on the current f_* values, i.e. before any same-cycle update):
  - 000 always
  - 001 eq: f_zf
  - 010 ne: ~f_zf
  - 011 lt: f_sf
  - 100 ge: ~f_sf
  - 101 cs: f_cf
  - 110 cc: ~f_cf
  - 111 le: f_zf | f_sf
- **Branch resolution:**
  - br_taken <= acc & ex_br & cond_true.
  - br_target <= ex_target when that term is 1; otherwise br_target holds.
- **Same instruction with ex_setf and ex_br:** the branch uses the old flags; the flags update afterwards.
- **Signed conditions:** use the sign flag only (no overflow term). This is a deliberate architecture decision.

## Timing
- **Reset** (clrn = 0, asynchronous, immediate): all mm_* = 0, f_zf = f_sf = f_cf = 0, br_taken = 0, br_target = 0.
- **Latency:** 1 cycle from EX inputs to mm_* / br_* outputs. The flag update is visible on f_* one cycle after capture.
- **br_taken** is a single-cycle pulse. It is never held across a stall.
- **Back-to-back flag dependency:** a flag-setting instruction in cycle N followed by a branch in EX in cycle N+1 sees the updated flags, with no bubble needed.
- **Release from reset:** clrn release mid-cycle takes effect at the next rising edge; the first capture occurs then.
- **flush and stall both high:** bubble inserted, flags unchanged, br_taken = 0.

## Test plan
- **Reset:** assert clrn = 0 mid-cycle with registers loaded -> all outputs 0 immediately, without waiting for a clock edge.
- **Capture:** ex_valid = 1, ex_r = 0x0000_1234, ex_rd = 5, ex_wreg = 1, ex_setf = 1, ex_zf = 0, ex_sf = 0, ex_cf = 1 -> next cycle mm_r = 0x1234, mm_rd = 5, mm_wreg = 1, mm_valid = 1, f_cf = 1, f_zf = 0.
- **Flag dependency:** SUB with ex_zf = 1, ex_setf = 1, then branch ex_cond = 001, ex_target = 0x0000_0040 -> br_taken = 1 for exactly one cycle with br_target = 0x40. Repeat with ex_cond = 010 -> br_taken = 0.
- **Same-instruction set and branch:** f_zf = 0; one instruction with ex_setf = 1, ex_zf = 1, ex_br = 1, ex_cond = 001 -> br_taken = 0 (old flag used), then f_zf = 1.
- **Stall:** stall = 1 for 3 cycles with changing inputs -> mm_* and f_* constant, br_taken = 0. On release, the next valid input is captured.
- **Flush:** flush = 1 together with stall = 1 and a valid store (ex_wmem = 1, ex_setf = 1) -> mm_valid = 0, mm_wmem = 0, flags unchanged, br_taken = 0.
